collatz_dp: RTL and testbench

- Datapath responder for the Collatz control FSM (H/I/O/E strobe sequencer).
- Consumes that FSM's eight registered control strobes (Mx, Rx, Ik, Pk, Sk, Mr, Pr, Ir).
- Returns the status the FSM branches on: co (captured seed), r (parity), k (running value).
- Also accumulates run statistics (step count, peak value, overflow/error flags) and a done indication for the top level.

---
 rtl/collatz_dp_pkg.sv | 14 +
 rtl/collatz_alu.sv | 30 +++
 rtl/collatz_dp.sv | 113 +++++++++++
 tb/tb_collatz_dp.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/collatz_dp_pkg.sv
// rtl/collatz_dp_pkg.sv - shared widths and ALU op encoding for the Collatz datapath
package collatz_dp_pkg;

   localparam int SW_DEF = 8;
   localparam int VW_DEF = 20;
   localparam int CW_DEF = 16;

   typedef enum logic [1:0] {
      OP_HOLD   = 2'd0,
      OP_MUL3P1 = 2'd1,
      OP_HALF   = 2'd2
   } alu_op_e;

endpackage

// File: rtl/collatz_alu.sv
// rtl/collatz_alu.sv - combinational 3V+1 / V>>1 / pass with carry-out of 3V+1
module collatz_alu
   import collatz_dp_pkg::*;
#(
   parameter int VW = VW_DEF
) (
   input  alu_op_e       i_op,
   input  logic [VW-1:0] i_v,
   output logic [VW-1:0] o_res,
   output logic          o_carry
);

   logic [VW+1:0] w_ext;
   logic [VW+1:0] w_m3p1;

   // 3V+1 formed as V + 2V + 1 in two extra bits so the overflow is never lost
   assign w_ext   = {2'b00, i_v};
   assign w_m3p1  = w_ext + {w_ext[VW:0], 1'b0} + (VW+2)'(1);
   assign o_carry = |w_m3p1[VW+1:VW];

   always_comb begin
      o_res = i_v;
      case (i_op)
         OP_MUL3P1: o_res = w_m3p1[VW-1:0];
         OP_HALF:   o_res = {1'b0, i_v[VW-1:1]};
         default:   o_res = i_v;
      endcase
   end

endmodule

// File: rtl/collatz_dp.sv
// rtl/collatz_dp.sv - Collatz datapath: seed capture, running value, step/peak stats, flags
module collatz_dp
   import collatz_dp_pkg::*;
#(
   parameter int SW = SW_DEF,
   parameter int VW = VW_DEF,
   parameter int CW = CW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [SW-1:0] seed,
   input  logic          Mx,
   input  logic          Rx,
   input  logic          Ik,
   input  logic          Pk,
   input  logic          Sk,
   input  logic          Mr,
   input  logic          Pr,
   input  logic          Ir,
   output logic [SW-1:0] co,
   output logic          r,
   output logic [VW-1:0] k,
   output logic [CW-1:0] steps,
   output logic [VW-1:0] peak,
   output logic          ovf,
   output logic          err,
   output logic          done
);

   logic [SW-1:0] r_co;
   logic [VW-1:0] r_v;
   logic [CW-1:0] r_steps;
   logic [VW-1:0] r_peak;
   logic          r_ovf;
   logic          r_err;
   logic          r_done;
   logic          r_ir_d;

   alu_op_e       w_op;
   logic [VW-1:0] w_alu;
   logic          w_carry;
   logic          w_load;
   logic [VW-1:0] w_next_v;
   logic          w_ovf_set;
   logic          w_err_set;
   logic          w_done_set;

   // Mr wins over Pr; the both-high case is still flagged through err
   assign w_op = Mr ? OP_MUL3P1 : (Pr ? OP_HALF : OP_HOLD);

   collatz_alu #(.VW(VW)) u_alu (
      .i_op    (w_op),
      .i_v     (r_v),
      .o_res   (w_alu),
      .o_carry (w_carry)
   );

   assign w_load     = Ik | Pk;
   assign w_next_v   = Mx ? w_alu : {{(VW-SW){1'b0}}, seed};
   assign w_ovf_set  = Mr & w_load & w_carry;
   assign w_err_set  = (w_load & ~Mx & (seed == '0)) | (Mr & Pr);
   assign w_done_set = (Ir & ~r_ir_d) | (Ir & Ik & ~Mx & (seed == SW'(1)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_co    <= '0;
         r_v     <= '0;
         r_steps <= '0;
         r_peak  <= '0;
         r_ovf   <= 1'b0;
         r_err   <= 1'b0;
         r_done  <= 1'b0;
         r_ir_d  <= 1'b0;
      end else begin
         r_ir_d <= Ir;
         if (Ir)
            r_co <= seed;
         if (w_load)
            r_v <= w_next_v;

         if (Sk)
            r_steps <= '0;
         else if (Mx && w_load && (r_steps != '1))
            r_steps <= r_steps + CW'(1);

         // a clear in the same edge as a load restarts the maximum at the new value
         if (w_load) begin
            if (Rx || (w_next_v > r_peak))
               r_peak <= w_next_v;
         end else if (Rx) begin
            r_peak <= '0;
         end

         r_ovf <= w_ovf_set | (r_ovf & ~Rx);
         r_err <= w_err_set | (r_err & ~Rx);

         if (Sk)
            r_done <= 1'b0;
         else if (w_done_set)
            r_done <= 1'b1;
      end
   end

   assign co    = r_co;
   assign r     = r_v[0];
   assign k     = r_v;
   assign steps = r_steps;
   assign peak  = r_peak;
   assign ovf   = r_ovf;
   assign err   = r_err;
   assign done  = r_done;

endmodule

// File: tb/tb_collatz_dp.sv
// tb/tb_collatz_dp.sv - directed self-checking bench for collatz_dp
module tb_collatz_dp;

   logic        clk;
   logic        rst_n;
   logic [7:0]  seed;
   logic        Mx, Rx, Ik, Pk, Sk, Mr, Pr, Ir;
   logic [7:0]  co;
   logic        r;
   logic [19:0] k;
   logic [15:0] steps;
   logic [19:0] peak;
   logic        ovf, err, done;

   int n_checks;
   int n_fails;

   collatz_dp dut (
      .clk   (clk),
      .rst_n (rst_n),
      .seed  (seed),
      .Mx    (Mx),
      .Rx    (Rx),
      .Ik    (Ik),
      .Pk    (Pk),
      .Sk    (Sk),
      .Mr    (Mr),
      .Pr    (Pr),
      .Ir    (Ir),
      .co    (co),
      .r     (r),
      .k     (k),
      .steps (steps),
      .peak  (peak),
      .ovf   (ovf),
      .err   (err),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_strobes();
      Mx = 0; Rx = 0; Ik = 0; Pk = 0; Sk = 0; Mr = 0; Pr = 0; Ir = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Emulates the control FSM: clear, load seed in H, then O/E steps until V==1, return to H
   task automatic run_seed(input logic [7:0] s, input int max_steps, input bit trace6);
      int mv;
      int n;
      int exp_k6[9];
      exp_k6 = '{6, 3, 10, 5, 16, 8, 4, 2, 1};
      idle_strobes();
      seed = s; Ir = 1; Rx = 1; Sk = 1;
      tick();
      idle_strobes();
      Ir = 1; Ik = 1; Mx = 0;
      tick();
      mv = int'(s);
      n  = 0;
      if (trace6) chk("k6_0", 32'(k), 32'(exp_k6[0]));
      idle_strobes();
      while (mv != 1 && n < max_steps) begin
         idle_strobes();
         Mx = 1;
         if (mv % 2 == 1) begin
            Ik = 1; Mr = 1; mv = 3 * mv + 1;
         end else begin
            Pk = 1; Pr = 1; mv = mv / 2;
         end
         tick();
         n++;
         if (trace6 && n < 9) chk($sformatf("k6_%0d", n), 32'(k), 32'(exp_k6[n]));
      end
      if (mv != 1) chk("step_bound", 32'(n), 32'(max_steps + 1));
      idle_strobes();
      Ir = 1;
      if (s != 8'd1) tick();
   endtask

   initial begin
      n_checks = 0;
      n_fails  = 0;
      idle_strobes();
      seed  = 8'd0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_k", 32'(k), 0);
      chk("rst_steps", 32'(steps), 0);
      chk("rst_done", 32'(done), 0);
      rst_n = 1'b1;

      // Partial run of seed 13 (13,40,20,10), then asynchronous reset mid-cycle
      seed = 8'd13; Ir = 1; Rx = 1; Sk = 1;
      tick();
      idle_strobes(); Ir = 1; Ik = 1;
      tick();
      idle_strobes(); Mx = 1; Ik = 1; Mr = 1; tick();
      idle_strobes(); Mx = 1; Pk = 1; Pr = 1; tick();
      idle_strobes(); Mx = 1; Pk = 1; Pr = 1; tick();
      idle_strobes();
      chk("pre_rst_k", 32'(k), 10);
      chk("pre_rst_steps", 32'(steps), 3);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_k", 32'(k), 0);
      chk("arst_steps", 32'(steps), 0);
      chk("arst_peak", 32'(peak), 0);
      chk("arst_co", 32'(co), 0);
      chk("arst_r", 32'(r), 0);
      chk("arst_flags", {29'd0, ovf, err, done}, 0);
      tick();
      rst_n = 1'b1;

      run_seed(8'd6, 50, 1'b1);
      chk("s6_steps", 32'(steps), 8);
      chk("s6_peak", 32'(peak), 16);
      chk("s6_done", 32'(done), 1);
      chk("s6_ovf", 32'(ovf), 0);
      chk("s6_err", 32'(err), 0);
      chk("s6_co", 32'(co), 6);

      run_seed(8'd1, 50, 1'b0);
      chk("s1_k", 32'(k), 1);
      chk("s1_steps", 32'(steps), 0);
      chk("s1_peak", 32'(peak), 1);
      chk("s1_done", 32'(done), 1);

      run_seed(8'd27, 300, 1'b0);
      chk("s27_steps", 32'(steps), 111);
      chk("s27_peak", 32'(peak), 9232);
      chk("s27_k", 32'(k), 1);
      chk("s27_done", 32'(done), 1);

      // Direct strobes: repeated 3V+1 from 255 until it overflows 20 bits
      idle_strobes(); seed = 8'd255; Ir = 1; Rx = 1; Sk = 1; tick();
      idle_strobes(); Ir = 1; Ik = 1; tick();
      for (int i = 0; i < 7; i++) begin
         idle_strobes(); Mx = 1; Ik = 1; Mr = 1; tick();
      end
      chk("d_k7", 32'(k), 558778);
      chk("d_ovf7", 32'(ovf), 0);
      idle_strobes(); Mx = 1; Ik = 1; Mr = 1; tick();
      chk("d_k8", 32'(k), 32'h9942F);
      chk("d_ovf8", 32'(ovf), 1);
      chk("d_peak8", 32'(peak), 32'h9942F);
      idle_strobes(); Rx = 1; tick();
      chk("d_rx_ovf", 32'(ovf), 0);
      chk("d_rx_peak", 32'(peak), 0);
      chk("d_rx_err", 32'(err), 0);
      idle_strobes(); Mx = 1; Ik = 1; Mr = 1; Pr = 1; tick();
      chk("d_both_err", 32'(err), 1);
      chk("d_both_k", 32'(k), 32'hCBC8E);
      chk("d_both_peak", 32'(peak), 32'hCBC8E);

      // Zero seed flags err; then step counter clear priority and saturation
      idle_strobes(); Rx = 1; tick();
      chk("z_err_clr", 32'(err), 0);
      idle_strobes(); seed = 8'd0; Ir = 1; Ik = 1; tick();
      chk("z_err", 32'(err), 1);
      chk("z_k", 32'(k), 0);
      idle_strobes(); Mx = 1; Ik = 1; Sk = 1;
      repeat (200) @(posedge clk);
      #1;
      chk("sat_sk_hold", 32'(steps), 0);
      Sk = 0;
      repeat (65534) @(posedge clk);
      #1;
      chk("sat_fffe", 32'(steps), 32'hFFFE);
      tick();
      chk("sat_ffff", 32'(steps), 32'hFFFF);
      repeat (3) @(posedge clk);
      #1;
      chk("sat_hold", 32'(steps), 32'hFFFF);
      idle_strobes();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
